// File: rtl/des_pkg.sv
// Shared DES key-schedule tables and shifter control codes.
package des_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    ROUND
  } state_t;

  localparam logic [2:0] SH_LOAD_ENC = 3'b000;
  localparam logic [2:0] SH_LOAD_DEC = 3'b100;
  localparam logic [2:0] SH_L1       = 3'b001;
  localparam logic [2:0] SH_L2       = 3'b010;
  localparam logic [2:0] SH_R1       = 3'b101;
  localparam logic [2:0] SH_R2       = 3'b110;
  localparam logic [2:0] SH_HOLD     = 3'b011;

  // Rounds 1, 2, 9 and 16 rotate by one; the rest by two
  localparam logic [1:16] ROT_ONE = 16'b1100_0000_1000_0001;

  localparam int unsigned PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  // Decrypt round r undoes encrypt round 18-r, which has the same
  // single/double pattern as round r for r>=2; round 1 presents C0D0.
  function automatic logic [2:0] round_code(
    input logic       dec,
    input logic [4:0] r
  );
    logic [2:0] code;
    code = SH_HOLD;
    if (dec)
      code = (r == 5'd1) ? SH_HOLD :
             (ROT_ONE[r] ? SH_R1 : SH_R2);
    else
      code = ROT_ONE[r] ? SH_L1 : SH_L2;
    return code;
  endfunction

endpackage

// File: rtl/des_pc1.sv
// DES permuted choice 1: 64-bit key to 28-bit C0 and D0 halves.
module des_pc1
  import des_pkg::*;
(
  input  logic [1:64] key,
  output logic [1:28] c,
  output logic [1:28] d
);

  for (genvar i = 1; i <= 28; i++) begin : g_bit
    assign c[i] = key[PC1[i-1]];
    assign d[i] = key[PC1[i+27]];
  end

  logic unused_parity;
  assign unused_parity = ^{key[8],  key[16], key[24], key[32],
                           key[40], key[48], key[56], key[64]};

endmodule

// File: rtl/des_key_sched_ctrl.sv
// Key-schedule sequencer: PC-1 load, then sixteen shift codes for the
// C/D rotation shifter, with a round-aligned subkey strobe.
module des_key_sched_ctrl
  import des_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [1:64] key,
  input  logic        start,
  input  logic        decrypt,
  input  logic        step,
  output logic [1:28] datac,
  output logic [1:28] datad,
  output logic [1:3]  shift,
  output logic        busy,
  output logic        rk_valid,
  output logic [4:0]  round,
  output logic        done
);

  state_t     state, state_n;
  logic [4:0] cnt, cnt_n;
  logic [4:0] code_rnd, code_rnd_n;
  logic       dec, dec_n;
  logic [2:0] shift_n;
  logic       load;
  logic [1:28] pc1_c, pc1_d;

  des_pc1 u_pc1 (
    .key (key),
    .c   (pc1_c),
    .d   (pc1_d)
  );

  // cnt counts codes already issued; code_rnd tags the code on shift
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    dec_n      = dec;
    code_rnd_n = '0;
    shift_n    = SH_HOLD;
    load       = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          dec_n   = decrypt;
          shift_n = decrypt ? SH_LOAD_DEC : SH_LOAD_ENC;
          state_n = LOAD;
        end
      end
      LOAD: begin
        shift_n    = round_code(dec, 5'd1);
        code_rnd_n = 5'd1;
        cnt_n      = 5'd1;
        state_n    = ROUND;
      end
      ROUND: begin
        if (cnt == 5'd16) begin
          cnt_n   = '0;
          state_n = IDLE;
        end else if (step) begin
          shift_n    = round_code(dec, cnt + 5'd1);
          code_rnd_n = cnt + 5'd1;
          cnt_n      = cnt + 5'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      dec      <= 1'b0;
      code_rnd <= '0;
      shift    <= SH_HOLD;
      busy     <= 1'b0;
      rk_valid <= 1'b0;
      round    <= '0;
      done     <= 1'b0;
      datac    <= '0;
      datad    <= '0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      dec      <= dec_n;
      code_rnd <= code_rnd_n;
      shift    <= shift_n;
      busy     <= (state_n != IDLE);
      rk_valid <= (code_rnd != 5'd0);
      round    <= code_rnd;
      done     <= (code_rnd == 5'd16);
      if (load) begin
        datac <= pc1_c;
        datad <= pc1_d;
      end
    end
  end

endmodule

// File: doc/des_key_sched_ctrl.md
# des_key_sched_ctrl

Sequencer that sits directly upstream of the DES C/D rotation shifter in the key schedule. It accepts a 64-bit DES key and applies PC-1 to form the 28-bit C0/D0 halves. It then emits one load code followed by sixteen per-round shift codes, so the shifter produces the encrypt schedule (left rotations) or the decrypt schedule (right rotations). A round-aligned valid/index strobe tells the downstream PC-2 stage which subkey the shifter is presenting.

## Interface
- No parameters; all tables are fixed by FIPS 46-3.
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- key  in  [1:64]  DES key, FIPS bit order; parity bits 8,16,…,64 ignored
- start  in  1  request a schedule; sampled only while busy=0
- decrypt  in  1  sampled with start; 1 selects the decrypt (right-rotate) schedule
- step  in  1  advance enable from the consumer; 0 stalls the round sequence
- datac  out  [1:28]  PC-1 C0 half, registered, to shifter datac
- datad  out  [1:28]  PC-1 D0 half, registered, to shifter datad
- shift  out  [1:3]  shifter control code, registered
- busy  out  1  high from the cycle after start acceptance through the final shift code
- rk_valid  out  1  shifter output in this cycle holds the subkey for round
- round  out  [4:0]  round index 1..16 valid with rk_valid, else 0
- done  out  1  one-cycle pulse coincident with rk_valid for round 16

## Operation
- Shift codes:
  - 000: load, encrypt
  - 100: load, decrypt
  - 001: left 1
  - 010: left 2
  - 101: right 1
  - 110: right 2
  - 011: hold (the shifter keeps its contents)
- Reset and idle value of shift is 011.
- Reset values: datac=0, datad=0, shift=011, busy=0, rk_valid=0, round=0, done=0. The FSM resets to IDLE and the round counter to 0.
- FSM states:
  - IDLE: start=1 latches decrypt, registers PC-1(key) into datac/datad and drives the load code (000 or 100) → LOAD.
  - LOAD: one cycle, step ignored → ROUND with counter=1.
  - ROUND, step=1: emit the code for the current counter and increment it. After round 16 → IDLE.
  - ROUND, step=0: emit 011 and keep the counter unchanged.
- Encrypt codes: rounds 1, 2, 9, 16 use 001; all other rounds use 010.
- Decrypt codes: round 1 uses 011 (K16 = C0D0); rounds 2, 9, 16 use 101; all other rounds use 110.
- datac/datad stay constant from LOAD until the next accepted start.
- start while busy=1 is ignored; no queuing.
- Asserting rst mid-schedule aborts immediately with all outputs at reset values. The shifter contents are then don't-care until the next load.

## Timing
- start accepted in cycle t: load code on shift in cycle t+1, busy=1 from t+1.
- Round-r code is presented in cycle n (step=1). In cycle n+1 the shifter shows C_r/D_r, with rk_valid=1 and round=r (one-cycle aligned delay).
- With step held at 1, rk_valid pulses in cycles t+3..t+18, round 1..16, and done=1 in cycle t+18.
- busy falls in cycle t+18; a new start is accepted in that cycle.
- Each step=0 cycle inserts exactly one rk_valid=0 bubble; no codes are lost or repeated.

## Structure
- Shared package des_pkg:
  - the PC-1 permutation table
  - the shift-code constants listed under Operation
  - the 16-entry per-round single/double shift table
- One combinational sub-module, des_pc1 (key[1:64] → c[1:28], d[1:28]). It is reused by the software-model checker.

## Test plan
- Encrypt with key 133457799BBCDFF1 and step=1: datac=F0CCAAF and datad=556678F. After round 1 the shifter shows E19955F/AACCF1E. After round 16 it shows F0CCAAF/556678F and done=1 at t+18.
- Decrypt with the same key: the code sequence is 100, 011, 101, 110×6, 101, 110×6, 101. rk_valid round 1 shows F0CCAAF/556678F, and round 16 shows E19955F/AACCF1E.
- step toggled 1,0,1,0 through an encrypt schedule: shift shows 011 on every stall cycle. rk_valid gets a matching bubble, round stays monotonic 1..16, and the final shifter state is identical to the no-stall run.
- start pulsed again mid-schedule (round 5) with a different key: it is ignored, and datac/datad and the schedule are unchanged.
- rst asserted at round 8: all outputs return to reset values in the same cycle. A start after release gives a correct full schedule.
- Back-to-back: start in the cycle busy falls is accepted, and its load code appears the next cycle with no idle gap.
